// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: display fetch has absolute priority, a one-entry buffer feeds writer slots.
// Optional VGA_FB_SCALE2X_EN: half-resolution framebuffer, pixels and lines shown twice.
module vga_fb_arbiter #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int COUNTER_BITS = 10,
    parameter int ADDR_BITS    = 19,
    parameter int PIXEL_BITS   = 24
) (
    input  logic                    clk_50MHz,
    input  logic                    clear,
    input  logic                    pixel_tick,
    input  logic [COUNTER_BITS-1:0] h_count,
    input  logic [COUNTER_BITS-1:0] v_count,
    input  logic                    bright_in,
    input  logic                    h_sync_in,
    input  logic                    v_sync_in,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_BITS-1:0]    wr_addr,
    input  logic [PIXEL_BITS-1:0]   wr_data,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_BITS-1:0]    mem_addr,
    output logic [PIXEL_BITS-1:0]   mem_wdata,
    input  logic [PIXEL_BITS-1:0]   mem_rdata,
    output logic [7:0]              red_out,
    output logic [7:0]              green_out,
    output logic [7:0]              blue_out,
    output logic                    h_sync_out,
    output logic                    v_sync_out,
    output logic                    bright_out
);

    if (ADDR_BITS < $clog2(H_RES * V_RES)) begin : g_addr_width_check
        $error("vga_fb_arbiter: ADDR_BITS cannot address H_RES*V_RES words");
    end

    logic                  disp_s, wr_issue_s, wr_ready_s, wr_accept_s;
    logic [ADDR_BITS-1:0]  disp_addr_s;

    logic                  pend_valid_q, pend_valid_d;
    logic [ADDR_BITS-1:0]  pend_addr_q, pend_addr_d;
    logic [PIXEL_BITS-1:0] pend_data_q, pend_data_d;

    logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
    logic [PIXEL_BITS-1:0] mem_wdata_q, mem_wdata_d;

    logic p1_tick_q, p1_rd_q, p1_br_q, p1_hs_q, p1_vs_q;
    logic p2_tick_q, p2_rd_q, p2_br_q, p2_hs_q, p2_vs_q;
    logic                  bright_q, hs_q, vs_q;
    logic [PIXEL_BITS-1:0] colour_q;

    // Slot decision: an active-video read pre-empts the buffered write
    always_comb begin
`ifdef VGA_FB_SCALE2X_EN
        disp_s      = pixel_tick & bright_in & ~h_count[0];
        disp_addr_s = ADDR_BITS'(32'(v_count >> 1) * 32'(H_RES / 2) + 32'(h_count >> 1));
`else
        disp_s      = pixel_tick & bright_in;
        disp_addr_s = ADDR_BITS'(32'(v_count) * 32'(H_RES) + 32'(h_count));
`endif
        wr_issue_s  = ~disp_s & pend_valid_q;
        wr_ready_s  = clear & (~pend_valid_q | wr_issue_s);
        wr_accept_s = wr_valid & wr_ready_s;
    end

    // Next state of the write buffer and of the registered RAM request
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if (wr_accept_s) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = wr_addr;
            pend_data_d  = wr_data;
        end else if (wr_issue_s) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end
        if (disp_s) begin
            mem_en_d   = 1'b1;
            mem_addr_d = disp_addr_s;
        end else if (pend_valid_q) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = pend_addr_q;
            mem_wdata_d = pend_data_q;
        end else begin
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
        end
    end

    // Write buffer and RAM request registers
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Two-stage tick pipeline covering the RAM address and read-data latency
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            {p1_tick_q, p1_rd_q, p1_br_q} <= 3'b000;
            {p1_hs_q, p1_vs_q}            <= 2'b11;
            {p2_tick_q, p2_rd_q, p2_br_q} <= 3'b000;
            {p2_hs_q, p2_vs_q}            <= 2'b11;
        end else begin
            {p1_tick_q, p1_rd_q, p1_br_q} <= {pixel_tick, disp_s, bright_in};
            {p1_hs_q, p1_vs_q}            <= {h_sync_in, v_sync_in};
            {p2_tick_q, p2_rd_q, p2_br_q} <= {p1_tick_q, p1_rd_q, p1_br_q};
            {p2_hs_q, p2_vs_q}            <= {p1_hs_q, p1_vs_q};
        end
    end

`ifdef VGA_FB_SCALE2X_EN
    logic [PIXEL_BITS-1:0] last_rd_q;

    // Last fetched word, re-presented on odd (repeated) pixels
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            last_rd_q <= '0;
        end else if (p2_tick_q && p2_rd_q) begin
            last_rd_q <= mem_rdata;
        end else begin
            last_rd_q <= last_rd_q;
        end
    end
`endif

    // Output stage: colour, blank and syncs all change on the same edge
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            colour_q <= '0;
            bright_q <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
        end else if (p2_tick_q) begin
            bright_q <= p2_br_q;
            hs_q     <= p2_hs_q;
            vs_q     <= p2_vs_q;
            if (p2_rd_q) begin
                colour_q <= mem_rdata;
`ifdef VGA_FB_SCALE2X_EN
            end else if (p2_br_q) begin
                colour_q <= last_rd_q;
`endif
            end else begin
                colour_q <= '0;
            end
        end else begin
            colour_q <= colour_q;
        end
    end

    assign wr_ready   = wr_ready_s;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign red_out    = colour_q[23:16];
    assign green_out  = colour_q[15:8];
    assign blue_out   = colour_q[7:0];
    assign bright_out = bright_q;
    assign h_sync_out = hs_q;
    assign v_sync_out = vs_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomised bench for vga_fb_arbiter with a queue-based reference model and a behavioural RAM.
module tb_vga_fb_arbiter;
    localparam int H_RES = 640;
`ifdef VGA_FB_SCALE2X_EN
    localparam int DH = 6, DV = 3, DADDR = 323;
`else
    localparam int DH = 5, DV = 2, DADDR = 1285;
`endif

    logic        clk_50MHz = 1'b0;
    logic        clear, pixel_tick, bright_in, h_sync_in, v_sync_in, wr_valid, wr_ready;
    logic [9:0]  h_count, v_count;
    logic [18:0] wr_addr, mem_addr;
    logic [23:0] wr_data, mem_wdata, mem_rdata;
    logic        mem_en, mem_we, h_sync_out, v_sync_out, bright_out;
    logic [7:0]  red_out, green_out, blue_out;

    vga_fb_arbiter dut (
        .clk_50MHz(clk_50MHz), .clear(clear), .pixel_tick(pixel_tick),
        .h_count(h_count), .v_count(v_count), .bright_in(bright_in),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .bright_out(bright_out)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Behavioural single-port RAM, 8K words visible to the bench
    logic [23:0] ram [0:8191];
    bit          written [0:8191];

    function automatic logic [23:0] init_word(input int a);
        if (a == 1285 || a == 323) return 24'hA1B2C3;
        return 24'(a * 40503 + 12345) ^ 24'h5A5A5A;
    endfunction

    function automatic logic [23:0] ram_word(input logic [18:0] a);
        logic [12:0] idx;
        idx = a[12:0];
        return written[idx] ? ram[idx] : init_word(int'(idx));
    endfunction

    always @(posedge clk_50MHz) begin
        if (mem_en && mem_we) begin
            ram[mem_addr[12:0]]     <= mem_wdata;
            written[mem_addr[12:0]] <= 1'b1;
        end
        if (mem_en && !mem_we) mem_rdata <= ram_word(mem_addr);
    end

    typedef struct {
        int          due;
        int          snap;
        bit          rd, br, hs, vs;
        logic [18:0] addr;
        logic [23:0] col;
    } rec_t;

    rec_t        recs[$];
    logic [42:0] wq[$];
    int          cyc = 0, n_tests = 0, n_fail = 0;
    bit          exp_en, exp_we, exp_rst, exp_br, exp_hs, exp_vs;
    logic [18:0] exp_addr;
    logic [23:0] exp_wdata, exp_col, last_word;

    bit          n_clear, n_tick, n_br, n_hs, n_vs, n_wv;
    int          n_h, n_v;
    logic [18:0] n_wa;
    logic [23:0] n_wd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [18:0] model_addr(input int h, input int v);
`ifdef VGA_FB_SCALE2X_EN
        return 19'((v / 2) * (H_RES / 2) + (h / 2));
`else
        return 19'(v * H_RES + h);
`endif
    endfunction

    // One clock: check registered outputs, drive new inputs, advance the model
    task automatic step();
        rec_t e;
        bit   disp, issue, ready;
        @(posedge clk_50MHz);
        #1;
        cyc++;
        foreach (recs[i]) begin
            if (recs[i].snap == cyc && recs[i].rd) begin
                recs[i].col = ram_word(recs[i].addr);
                last_word   = recs[i].col;
            end
        end
        if (recs.size() != 0 && recs[0].due == cyc) begin
            e = recs.pop_front();
            exp_col = e.col; exp_br = e.br; exp_hs = e.hs; exp_vs = e.vs;
        end
        check_eq("mem_en", 32'(mem_en), 32'(exp_en));
        check_eq("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_en || exp_rst) check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_we || exp_rst) check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        check_eq("rgb", 32'({red_out, green_out, blue_out}), 32'(exp_col));
        check_eq("bright_out", 32'(bright_out), 32'(exp_br));
        check_eq("syncs", 32'({h_sync_out, v_sync_out}), 32'({exp_hs, exp_vs}));

        clear = n_clear; pixel_tick = n_tick; bright_in = n_br;
        h_sync_in = n_hs; v_sync_in = n_vs; h_count = 10'(n_h); v_count = 10'(n_v);
        wr_valid = n_wv; wr_addr = n_wa; wr_data = n_wd;
        #1;

        if (!n_clear) begin
            wq.delete(); recs.delete();
            exp_en = 0; exp_we = 0; exp_rst = 1; exp_addr = '0; exp_wdata = '0;
            exp_col = '0; exp_br = 0; exp_hs = 1; exp_vs = 1; last_word = '0;
            check_eq("wr_ready_rst", 32'(wr_ready), 32'(0));
        end else begin
`ifdef VGA_FB_SCALE2X_EN
            disp = n_tick && n_br && (n_h % 2 == 0);
`else
            disp = n_tick && n_br;
`endif
            issue   = !disp && wq.size() != 0;
            ready   = wq.size() == 0 || issue;
            exp_rst = 0;
            check_eq("wr_ready", 32'(wr_ready), 32'(ready));
            if (disp) begin
                exp_en = 1; exp_we = 0; exp_addr = model_addr(n_h, n_v);
            end else if (issue) begin
                exp_en = 1; exp_we = 1; {exp_addr, exp_wdata} = wq.pop_front();
            end else begin
                exp_en = 0; exp_we = 0;
            end
            if (n_wv && ready) wq.push_back({n_wa, n_wd});
            if (n_tick) begin
                e.due = cyc + 3; e.snap = cyc + 1; e.rd = disp; e.br = n_br;
                e.hs = n_hs; e.vs = n_vs; e.addr = model_addr(n_h, n_v);
                e.col = (n_br && !disp) ? last_word : 24'h000000;
                recs.push_back(e);
            end
        end
    endtask

    initial begin
        clear = 1'b1;
        exp_en = 0; exp_we = 0; exp_rst = 1; exp_addr = '0; exp_wdata = '0;
        exp_col = '0; exp_br = 0; exp_hs = 1; exp_vs = 1; last_word = '0;
        n_clear = 0; n_tick = 0; n_br = 0; n_hs = 1; n_vs = 1; n_wv = 0;
        n_h = 0; n_v = 0; n_wa = '0; n_wd = '0;
        #1 clear = 1'b0;
        repeat (3) step();

        // Directed fetch, with a write pending around the tick
        n_clear = 1;
        repeat (2) step();
        n_tick = 1; n_br = 1; n_h = DH; n_v = DV; step();
        n_tick = 0; n_wv = 1; n_wa = 19'd100; n_wd = 24'h123456; step();
        check_eq("addr_directed", 32'(mem_addr), 32'(DADDR));
        n_tick = 1; n_wv = 0; n_h = DH + 1; step();
`ifdef VGA_FB_SCALE2X_EN
        check_eq("odd_tick_ready", 32'(wr_ready), 32'(1));
`else
        check_eq("tick_blocks_write", 32'(wr_ready), 32'(0));
`endif
        n_tick = 0; step();
        check_eq("rgb_directed", 32'({red_out, green_out, blue_out}), 32'(24'hA1B2C3));
        check_eq("bright_directed", 32'(bright_out), 32'(1));
        n_tick = 1; n_h = DH + 2; step();
        n_tick = 0; step();
`ifdef VGA_FB_SCALE2X_EN
        check_eq("rgb_repeat", 32'({red_out, green_out, blue_out}), 32'(24'hA1B2C3));
`endif

        // Reset mid-frame with a write accepted but not yet issued
        n_tick = 1; n_wv = 1; n_wa = 19'd200; n_wd = 24'hDEAD01; step();
        n_clear = 0; n_tick = 0; n_wv = 0;
        repeat (3) begin
            step();
            check_eq("rst_ready", 32'(wr_ready), 32'(0));
            check_eq("rst_syncs", 32'({h_sync_out, v_sync_out}), 32'(2'b11));
        end
        n_clear = 1;
        repeat (4) begin n_tick = !n_tick; step(); end

        // Blanking with the writer streaming
        n_br = 0; n_wv = 1;
        for (int k = 0; k < 20; k++) begin
            n_tick = !n_tick; n_wa = 19'($urandom_range(0, 8191)); n_wd = 24'($urandom);
            step();
            check_eq("blank_ready", 32'(wr_ready), 32'(1));
        end

        // Active video with the writer streaming
        n_br = 1;
        for (int k = 0; k < 40; k++) begin
            n_tick = !n_tick; n_h = k; n_v = 4;
            n_wa = 19'($urandom_range(0, 8191)); n_wd = 24'($urandom);
            step();
        end

        // Fully random traffic
        for (int k = 0; k < 3000; k++) begin
            n_tick  = !n_tick && ($urandom_range(0, 7) != 0);
            n_br    = $urandom_range(0, 3) != 0;
            n_hs    = 1'($urandom); n_vs = 1'($urandom);
            n_h     = $urandom_range(0, H_RES - 1); n_v = $urandom_range(0, 7);
            n_wv    = 1'($urandom);
            n_wa    = 19'($urandom_range(0, 8191)); n_wd = 24'($urandom);
            n_clear = $urandom_range(0, 599) != 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
